// File: rtl/wcu_multi.sv
// wcu_multi: shared car signal with N_REQ batched pedestrian crossings, integrated phase timing and night flash
module wcu_multi #(
    parameter int N_REQ    = 4,
    parameter int CW       = 6,
    parameter int T_GREEN  = 6,
    parameter int T_YELLOW = 2,
    parameter int T_WALK   = 4,
    parameter int T_CLEAR  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             night,
    output logic [1:0]       ts,
    output logic [N_REQ-1:0] walk,
    output logic [N_REQ-1:0] pend,
    output logic             lid
);
    typedef enum logic [2:0] {GREEN, YELLOW, WALK, CLEAR, FLASH_ON, FLASH_OFF} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [N_REQ-1:0] walk_n, pend_n;
    logic exp_g, exp_y, exp_w, exp_c;
    assign exp_g = cnt >= CW'(T_GREEN - 1);
    assign exp_y = cnt == CW'(T_YELLOW - 1);
    assign exp_w = cnt == CW'(T_WALK - 1);
    assign exp_c = cnt == CW'(T_CLEAR - 1);
    always_comb begin
        state_n = state;
        walk_n  = walk;
        pend_n  = pend | (req & ~walk);
        case (state)
            GREEN:     if (exp_g) state_n = night ? FLASH_ON : (|pend ? YELLOW : GREEN);
            YELLOW:    if (exp_y) begin
                state_n = WALK;
                walk_n  = pend;
                pend_n  = req & ~walk;
            end
            WALK:      if (exp_w) begin
                state_n = CLEAR;
                walk_n  = '0;
            end
            CLEAR:     if (exp_c) state_n = GREEN;
            FLASH_ON:  if (exp_y) state_n = FLASH_OFF;
            FLASH_OFF: if (exp_y) state_n = night ? FLASH_ON : GREEN;
            default:   state_n = GREEN;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= GREEN;
            cnt   <= '0;
            walk  <= '0;
            pend  <= '0;
            lid   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? '0 : (&cnt ? cnt : cnt + 1'b1);
            walk  <= walk_n;
            pend  <= pend_n;
            lid   <= |pend_n;
        end
    end
    assign ts = (state == GREEN) ? 2'b00 :
                (state == YELLOW || state == FLASH_ON) ? 2'b01 :
                (state == FLASH_OFF) ? 2'b11 : 2'b10;
endmodule

// File: tb/tb_wcu_multi.sv
// tb_wcu_multi: directed cycle-by-cycle vectors with hand-computed expectations
module tb_wcu_multi;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = '0;
    logic       night = 1'b0;
    logic [1:0] ts;
    logic [3:0] walk, pend;
    logic       lid;
    int n_vec = 0;
    int n_err = 0;

    wcu_multi dut (.clk(clk), .reset(reset), .req(req), .night(night),
                   .ts(ts), .walk(walk), .pend(pend), .lid(lid));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc_chk(input string sc, input int c, input logic [1:0] ts_e,
                           input logic [3:0] walk_e, input logic [3:0] pend_e);
        chk($sformatf("%s c%0d ts", sc, c), 32'(ts), 32'(ts_e));
        chk($sformatf("%s c%0d walk", sc, c), 32'(walk), 32'(walk_e));
        chk($sformatf("%s c%0d pend", sc, c), 32'(pend), 32'(pend_e));
        chk($sformatf("%s c%0d lid", sc, c), 32'(lid), 32'(|pend_e));
    endtask

    task automatic do_reset();
        req   = '0;
        night = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [1:0] ts2(input int c);
        return (c < 12) ? 2'b00 : (c < 14) ? 2'b01 : (c < 20) ? 2'b10 : 2'b00;
    endfunction
    function automatic logic [3:0] walk2(input int c);
        return (c >= 14 && c <= 17) ? 4'b0010 : 4'b0000;
    endfunction
    function automatic logic [3:0] pend2(input int c);
        return (c >= 11 && c <= 13) ? 4'b0010 : 4'b0000;
    endfunction

    task automatic run3(input string sc);
        for (int c = 0; c <= 12; c++) begin
            cyc_chk(sc, c,
                    (c < 6) ? 2'b00 : (c < 8) ? 2'b01 : 2'b10,
                    (c >= 8 && c <= 11) ? 4'b0001 : 4'b0000,
                    (c >= 3 && c <= 7) ? 4'b0001 : (c >= 8) ? 4'b0010 : 4'b0000);
            req = (c == 2) ? 4'b0001 : (c == 7) ? 4'b0010 : (c == 9) ? 4'b0001 : 4'b0000;
            @(negedge clk);
        end
        req = '0;
    endtask

    initial begin
        do_reset();
        for (int c = 0; c < 30; c++) begin
            cyc_chk("idle", c, 2'b00, 4'b0000, 4'b0000);
            @(negedge clk);
        end

        do_reset();
        for (int c = 0; c <= 21; c++) begin
            cyc_chk("single", c, ts2(c), walk2(c), pend2(c));
            req = (c == 10) ? 4'b0010 : 4'b0000;
            @(negedge clk);
        end

        do_reset();
        run3("early");

        do_reset();
        for (int c = 0; c <= 27; c++) begin
            cyc_chk("batch", c,
                    (c < 12) ? 2'b00 : (c < 14) ? 2'b01 : (c < 20) ? 2'b10 : (c < 26) ? 2'b00 : 2'b01,
                    (c >= 14 && c <= 17) ? 4'b1001 : 4'b0000,
                    (c == 11 || c == 12) ? 4'b0001 : (c == 13) ? 4'b1001 : (c >= 16) ? 4'b0100 : 4'b0000);
            req = (c == 10) ? 4'b0001 : (c == 12) ? 4'b1000 : (c == 15) ? 4'b0100 : 4'b0000;
            @(negedge clk);
        end

        do_reset();
        for (int c = 0; c <= 21; c++) begin
            cyc_chk("night", c,
                    (c < 6) ? 2'b00 : (c < 8) ? 2'b01 : (c < 10) ? 2'b11 : (c < 12) ? 2'b01 :
                    (c < 14) ? 2'b11 : (c < 20) ? 2'b00 : 2'b01,
                    4'b0000, (c >= 1) ? 4'b0001 : 4'b0000);
            req   = (c == 0) ? 4'b0001 : 4'b0000;
            night = (c >= 3 && c < 12);
            @(negedge clk);
        end
        night = 1'b0;

        do_reset();
        for (int c = 0; c <= 15; c++) begin
            cyc_chk("midrst", c, ts2(c), walk2(c), pend2(c));
            req   = (c == 10) ? 4'b0010 : 4'b0000;
            reset = (c != 15);
            @(negedge clk);
        end
        cyc_chk("midrst", 16, 2'b00, 4'b0000, 4'b0000);
        reset = 1'b1;
        run3("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
